// File: rtl/corr_window_sequencer_if.sv
// Bus bundle for corr_window_sequencer: row-buffer read side, correlation_line
// capture inputs and the window-sum valid/ready output.
interface corr_window_sequencer_if #(
    parameter int PIXEL_SIZE    = 8,
    parameter int LINE_SIZE     = 10,
    parameter int NUM_TEMPLATES = 10,
    parameter int T_ROWS        = 3,
    parameter int IMG_ROWS      = 5,
    parameter int ACC_W         = 2*PIXEL_SIZE + $clog2(T_ROWS+1)
);
    localparam int DW  = 2*PIXEL_SIZE;
    localparam int IAW = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
    localparam int TAW = (T_ROWS > 1) ? $clog2(T_ROWS) : 1;

    logic                                              start;
    logic                                              busy;
    logic                                              done;
    logic                                              row_rd_en;
    logic [IAW-1:0]                                    img_row_addr;
    logic [TAW-1:0]                                    tmpl_row_addr;
    logic [LINE_SIZE-1:0][DW-1:0]                      cl_I_line;
    logic [LINE_SIZE-1:0][DW-1:0]                      cl_I_square_line;
    logic [NUM_TEMPLATES-1:0][LINE_SIZE-1:0][DW-1:0]   cl_T_x_I_lines;
    logic [LINE_SIZE-1:0][ACC_W-1:0]                   sum_I;
    logic [LINE_SIZE-1:0][ACC_W-1:0]                   sum_I2;
    logic [NUM_TEMPLATES-1:0][LINE_SIZE-1:0][ACC_W-1:0] sum_TI;
    logic [IAW-1:0]                                    win_idx;
    logic                                              out_valid;
    logic                                              out_ready;

    modport master (
        input  start, cl_I_line, cl_I_square_line, cl_T_x_I_lines, out_ready,
        output busy, done, row_rd_en, img_row_addr, tmpl_row_addr,
               sum_I, sum_I2, sum_TI, win_idx, out_valid
    );

    modport slave (
        output start, cl_I_line, cl_I_square_line, cl_T_x_I_lines, out_ready,
        input  busy, done, row_rd_en, img_row_addr, tmpl_row_addr,
               sum_I, sum_I2, sum_TI, win_idx, out_valid
    );
endinterface

// File: rtl/corr_window_sequencer.sv
// Walks a T_ROWS window down the image, summing correlation_line outputs per column;
// each row costs 2+CL_LATENCY cycles, and a finished window holds in OUT until out_ready.
module corr_window_sequencer #(
    parameter int PIXEL_SIZE    = 8,
    parameter int LINE_SIZE     = 10,
    parameter int NUM_TEMPLATES = 10,
    parameter int T_ROWS        = 3,
    parameter int IMG_ROWS      = 5,
    parameter int CL_LATENCY    = 0,
    parameter int ACC_W         = 2*PIXEL_SIZE + $clog2(T_ROWS+1)
) (
    input  logic                    CLK,
    input  logic                    RST,
    corr_window_sequencer_if.master bus
);
    localparam int NUM_WIN = IMG_ROWS - T_ROWS + 1;
    localparam int IAW     = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;
    localparam int TAW     = (T_ROWS > 1) ? $clog2(T_ROWS) : 1;
    localparam int WCW     = (CL_LATENCY > 0) ? $clog2(CL_LATENCY+1) : 1;

    typedef enum logic [1:0] {IDLE, READ, WAIT, OUT} state_t;

    state_t         state_q, state_d;
    logic [TAW-1:0] row_q;
    logic [IAW-1:0] win_q;
    logic [WCW-1:0] wait_q;
    logic           done_q;
    logic           capture, first_row, last_row, last_win, handshake;

    logic [LINE_SIZE-1:0][ACC_W-1:0]                    acc_i;
    logic [LINE_SIZE-1:0][ACC_W-1:0]                    acc_i2;
    logic [NUM_TEMPLATES-1:0][LINE_SIZE-1:0][ACC_W-1:0] acc_ti;

    assign capture   = (state_q == WAIT) && (wait_q == WCW'(CL_LATENCY));
    assign first_row = (row_q == '0);
    assign last_row  = (row_q == TAW'(T_ROWS-1));
    assign last_win  = (win_q == IAW'(NUM_WIN-1));
    assign handshake = (state_q == OUT) && bus.out_ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = READ;
            READ:    state_d = WAIT;
            WAIT:    if (capture) state_d = last_row ? OUT : READ;
            OUT:     if (handshake) state_d = last_win ? IDLE : READ;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.row_rd_en = (state_q == READ);
        bus.out_valid = (state_q == OUT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            row_q  <= '0;
            win_q  <= '0;
            wait_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= handshake && last_win;
            case (state_q)
                IDLE: if (bus.start) begin
                    row_q <= '0;
                    win_q <= '0;
                end
                READ: wait_q <= '0;
                WAIT: begin
                    wait_q <= wait_q + 1'b1;
                    if (capture && !last_row) row_q <= row_q + 1'b1;
                end
                OUT: if (handshake && !last_win) begin
                    win_q <= win_q + 1'b1;
                    row_q <= '0;
                end
                default: ;
            endcase
        end
    end

    // Row 0 of each window overwrites the accumulators, so no separate clear cycle is needed.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_i  <= '0;
            acc_i2 <= '0;
            acc_ti <= '0;
        end else if (capture) begin
            for (int c = 0; c < LINE_SIZE; c++) begin
                acc_i[c]  <= (first_row ? ACC_W'(0) : acc_i[c])  + ACC_W'(bus.cl_I_line[c]);
                acc_i2[c] <= (first_row ? ACC_W'(0) : acc_i2[c]) + ACC_W'(bus.cl_I_square_line[c]);
                for (int k = 0; k < NUM_TEMPLATES; k++) begin
                    acc_ti[k][c] <= (first_row ? ACC_W'(0) : acc_ti[k][c])
                                    + ACC_W'(bus.cl_T_x_I_lines[k][c]);
                end
            end
        end
    end

    assign bus.done          = done_q;
    assign bus.img_row_addr  = win_q + IAW'(row_q);
    assign bus.tmpl_row_addr = row_q;
    assign bus.win_idx       = win_q;
    assign bus.sum_I         = acc_i;
    assign bus.sum_I2        = acc_i2;
    assign bus.sum_TI        = acc_ti;
endmodule

// File: tb/tb_corr_window_sequencer.sv
// Bench for corr_window_sequencer: three parameterisations, row-buffer/correlation_line
// models feeding each, and window sums checked against arithmetic over the image arrays.
module tb_corr_window_sequencer;
    localparam int PS = 8;
    localparam int LS = 10;
    localparam int NT = 10;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    // A: CL_LATENCY=1, T_ROWS=3, IMG_ROWS=5; B: 0/1/1; C: 2/3/3 at full-scale pixels
    corr_window_sequencer_if #(.PIXEL_SIZE(PS), .LINE_SIZE(LS), .NUM_TEMPLATES(NT),
                               .T_ROWS(3), .IMG_ROWS(5)) ia ();
    corr_window_sequencer_if #(.PIXEL_SIZE(PS), .LINE_SIZE(LS), .NUM_TEMPLATES(NT),
                               .T_ROWS(1), .IMG_ROWS(1)) ib ();
    corr_window_sequencer_if #(.PIXEL_SIZE(PS), .LINE_SIZE(LS), .NUM_TEMPLATES(NT),
                               .T_ROWS(3), .IMG_ROWS(3)) ic ();

    corr_window_sequencer #(.PIXEL_SIZE(PS), .LINE_SIZE(LS), .NUM_TEMPLATES(NT),
                            .T_ROWS(3), .IMG_ROWS(5), .CL_LATENCY(1))
        dut_a (.CLK(CLK), .RST(RST), .bus(ia));
    corr_window_sequencer #(.PIXEL_SIZE(PS), .LINE_SIZE(LS), .NUM_TEMPLATES(NT),
                            .T_ROWS(1), .IMG_ROWS(1), .CL_LATENCY(0))
        dut_b (.CLK(CLK), .RST(RST), .bus(ib));
    corr_window_sequencer #(.PIXEL_SIZE(PS), .LINE_SIZE(LS), .NUM_TEMPLATES(NT),
                            .T_ROWS(3), .IMG_ROWS(3), .CL_LATENCY(2))
        dut_c (.CLK(CLK), .RST(RST), .bus(ic));

    // Image pixel per row/column, and per-template multiplier per template row
    int img_a [5][LS];
    int tm_a  [NT][3];

    // A: buffer read register, then one correlation_line stage; outputs 0 when nothing valid
    logic [2:0] ra = '0, ra1 = '0;
    logic [1:0] ta = '0, ta1 = '0;
    logic       va0 = 1'b0, va1 = 1'b0;
    always @(posedge CLK) begin
        va0 <= ia.row_rd_en;
        if (ia.row_rd_en) begin
            ra <= ia.img_row_addr;
            ta <= ia.tmpl_row_addr;
        end
        va1 <= va0;
        ra1 <= ra;
        ta1 <= ta;
    end
    always_comb begin
        for (int c = 0; c < LS; c++) begin
            int p;
            p = va1 ? img_a[ra1][c] : 0;
            ia.cl_I_line[c]        = 16'(p);
            ia.cl_I_square_line[c] = 16'(p*p);
            for (int k = 0; k < NT; k++) ia.cl_T_x_I_lines[k][c] = 16'(tm_a[k][ta1]*p);
        end
    end

    // B: combinational correlation_line, single image row of value 1, template 2
    logic vb = 1'b0;
    always @(posedge CLK) vb <= ib.row_rd_en;
    always_comb begin
        for (int c = 0; c < LS; c++) begin
            ib.cl_I_line[c]        = vb ? 16'd1 : 16'd0;
            ib.cl_I_square_line[c] = vb ? 16'd1 : 16'd0;
            for (int k = 0; k < NT; k++) ib.cl_T_x_I_lines[k][c] = vb ? 16'd2 : 16'd0;
        end
    end

    // C: two correlation_line stages, every pixel 255, template 2
    logic [2:0] vc = '0;
    always @(posedge CLK) vc <= {vc[1:0], ic.row_rd_en};
    always_comb begin
        for (int c = 0; c < LS; c++) begin
            ic.cl_I_line[c]        = vc[2] ? 16'd255 : 16'd0;
            ic.cl_I_square_line[c] = vc[2] ? 16'd65025 : 16'd0;
            for (int k = 0; k < NT; k++) ic.cl_T_x_I_lines[k][c] = vc[2] ? 16'd510 : 16'd0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic fill_a(input bit rnd);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < LS; c++) img_a[r][c] = rnd ? int'($urandom_range(0, 255)) : r + 1;
        for (int k = 0; k < NT; k++)
            for (int t = 0; t < 3; t++) tm_a[k][t] = rnd ? int'($urandom_range(0, 255)) : 2;
    endtask

    // kind 0: I, 1: I^2, 2: T x I for template k; window w covers image rows w..w+2
    function automatic longint exp_a(input int kind, input int w, input int c, input int k);
        longint s = 0;
        for (int t = 0; t < 3; t++) begin
            longint p = img_a[w+t][c];
            case (kind)
                0:       s += p;
                1:       s += p*p;
                default: s += tm_a[k][t]*p;
            endcase
        end
        return s;
    endfunction

    task automatic check_win_a(input int w);
        chk("win_idx", ia.win_idx, w);
        for (int c = 0; c < LS; c++) begin
            chk("sum_I", ia.sum_I[c], exp_a(0, w, c, 0));
            chk("sum_I2", ia.sum_I2[c], exp_a(1, w, c, 0));
            for (int k = 0; k < NT; k++) chk("sum_TI", ia.sum_TI[k][c], exp_a(2, w, c, k));
        end
    endtask

    task automatic zero_a();
        chk("rst_busy", ia.busy, 0);
        chk("rst_done", ia.done, 0);
        chk("rst_out_valid", ia.out_valid, 0);
        chk("rst_row_rd_en", ia.row_rd_en, 0);
        chk("rst_img_addr", ia.img_row_addr, 0);
        chk("rst_tmpl_addr", ia.tmpl_row_addr, 0);
        chk("rst_win_idx", ia.win_idx, 0);
        chk("rst_sum_I", ia.sum_I[0], 0);
        chk("rst_sum_I2", ia.sum_I2[LS-1], 0);
        chk("rst_sum_TI", ia.sum_TI[NT-1][LS-1], 0);
    endtask

    // Called at a negedge: that cycle is cycle 0 (start sampled). Returns at the done cycle.
    task automatic pass_a(input bit rnd, input bit bp, input bit hold_start);
        int n, w, stall, first_n;
        bit exp_rd;
        n = 0; w = 0; stall = 0; first_n = 0; exp_rd = 1'b0;
        ia.start = 1'b1;
        ia.out_ready = 1'b1;
        while (w < 3 && n < 3000) begin
            @(negedge CLK);
            n++;
            if (!hold_start) ia.start = 1'b0;
            if (n == 1) begin
                chk("first_read", ia.row_rd_en, 1);
                chk("busy", ia.busy, 1);
            end
            if (exp_rd) begin
                chk("read_after_handshake", ia.row_rd_en, 1);
                exp_rd = 1'b0;
            end
            if (ia.out_valid) begin
                if (first_n == 0) begin
                    first_n = n;
                    chk("first_valid_cycle", n, 10);
                end
                check_win_a(w);
                if (bp && w == 1 && stall < 20) begin
                    ia.out_ready = 1'b0;
                    chk("stall_no_read", ia.row_rd_en, 0);
                    stall++;
                end else begin
                    ia.out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
                if (ia.out_ready) begin
                    w++;
                    exp_rd = (w < 3);
                end
            end else begin
                chk("no_done_mid_pass", ia.done, 0);
                ia.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
        if (n >= 3000) chk("pass_timeout", 0, 1);
        @(negedge CLK);
        chk("done_pulse", ia.done, 1);
        chk("idle_in_done_cycle", ia.busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ia.start = 1'b0; ia.out_ready = 1'b0;
        ib.start = 1'b0; ib.out_ready = 1'b0;
        ic.start = 1'b0; ic.out_ready = 1'b0;
        fill_a(1'b0);
        repeat (2) @(negedge CLK);
        zero_a();
        chk("rst_b_valid", ib.out_valid, 0);
        chk("rst_c_busy", ic.busy, 0);
        RST = 1'b0;
        @(negedge CLK);

        // Basic pass with a 20-cycle stall on window 1
        pass_a(1'b0, 1'b1, 1'b0);
        @(negedge CLK);
        chk("done_one_cycle", ia.done, 0);

        // Reset during WAIT of window 1, row 2 (cycle 18)
        ia.start = 1'b1;
        @(negedge CLK);
        ia.start = 1'b0;
        repeat (17) @(negedge CLK);
        chk("mid_busy", ia.busy, 1);
        chk("mid_no_read", ia.row_rd_en, 0);
        chk("mid_win_idx", ia.win_idx, 1);
        chk("mid_img_addr", ia.img_row_addr, 3);
        chk("mid_tmpl_addr", ia.tmpl_row_addr, 2);
        #1 RST = 1'b1;
        #1 zero_a();
        @(negedge CLK);
        RST = 1'b0;
        pass_a(1'b0, 1'b0, 1'b0);
        @(negedge CLK);

        // Randomised image/templates and random back-pressure
        for (int i = 0; i < 3; i++) begin
            fill_a(1'b1);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            pass_a(1'b1, 1'b0, 1'b0);
            @(negedge CLK);
            chk("done_low_after", ia.done, 0);
        end

        // start held through two passes: restart only in the done cycle
        fill_a(1'b0);
        pass_a(1'b0, 1'b0, 1'b1);
        pass_a(1'b0, 1'b0, 1'b1);
        ia.start = 1'b0;
        @(negedge CLK);
        chk("held_end_done", ia.done, 0);
        chk("held_end_busy", ia.busy, 0);

        // B: single row, single window, combinational correlation_line
        ib.start = 1'b1;
        ib.out_ready = 1'b1;
        @(negedge CLK);
        ib.start = 1'b0;
        chk("b_read", ib.row_rd_en, 1);
        @(negedge CLK);
        chk("b_wait_no_valid", ib.out_valid, 0);
        @(negedge CLK);
        chk("b_valid", ib.out_valid, 1);
        chk("b_win_idx", ib.win_idx, 0);
        for (int c = 0; c < LS; c += LS-1) begin
            chk("b_sum_I", ib.sum_I[c], 1);
            chk("b_sum_I2", ib.sum_I2[c], 1);
            chk("b_sum_TI", ib.sum_TI[NT-1][c], 2);
        end
        @(negedge CLK);
        chk("b_done", ib.done, 1);
        chk("b_idle", ib.busy, 0);
        @(negedge CLK);
        chk("b_done_low", ib.done, 0);

        // C: CL_LATENCY=2, full-scale pixels
        ic.start = 1'b1;
        ic.out_ready = 1'b1;
        @(negedge CLK);
        ic.start = 1'b0;
        repeat (11) @(negedge CLK);
        chk("c_not_yet_valid", ic.out_valid, 0);
        @(negedge CLK);
        chk("c_valid", ic.out_valid, 1);
        for (int c = 0; c < LS; c += LS-1) begin
            chk("c_sum_I", ic.sum_I[c], 765);
            chk("c_sum_I2", ic.sum_I2[c], 195075);
            chk("c_sum_TI", ic.sum_TI[0][c], 1530);
        end
        @(negedge CLK);
        chk("c_done", ic.done, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/corr_window_sequencer.md
# corr_window_sequencer

Sequencer for the template-matching correlation datapath. It walks a vertical window of T_ROWS image rows down an IMG_ROWS-row image, one window position per step. For each row it issues read addresses to the image and template row buffers. The buffers feed correlation_line directly, and this block captures correlation_line's per-column I, I² and T×I lines and sums them over the window. Each finished window is presented on a valid/ready output for the downstream normalisation stage.

## Interface
- PIXEL_SIZE, 8, pixel width in bits
- LINE_SIZE, 10, pixels per line (columns)
- NUM_TEMPLATES, 10, templates correlated in parallel
- T_ROWS, 3, template height = rows summed per window (1..IMG_ROWS)
- IMG_ROWS, 5, image height; window count NUM_WIN = IMG_ROWS-T_ROWS+1
- CL_LATENCY, 0, register stages inside correlation_line (0 = combinational)
- ACC_W, 2*PIXEL_SIZE+$clog2(T_ROWS+1), accumulator width

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- start  in  1  begin a full image pass; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last window handshakes
- row_rd_en  out  1  read strobe to image/template row buffers (data valid next cycle)
- img_row_addr  out  $clog2(IMG_ROWS)  image row = win_idx + row_idx
- tmpl_row_addr  out  $clog2(T_ROWS)  template row = row_idx
- cl_I_line  in  LINE_SIZE×2*PIXEL_SIZE  correlation_line I output
- cl_I_square_line  in  LINE_SIZE×2*PIXEL_SIZE  correlation_line I² output
- cl_T_x_I_lines  in  NUM_TEMPLATES×LINE_SIZE×2*PIXEL_SIZE  correlation_line T×I output (transposed form)
- sum_I  out  LINE_SIZE×ACC_W  window column sums of I
- sum_I2  out  LINE_SIZE×ACC_W  window column sums of I²
- sum_TI  out  NUM_TEMPLATES×LINE_SIZE×ACC_W  window column sums of T×I
- win_idx  out  $clog2(IMG_ROWS)  top image row of the presented window
- out_valid  out  1  sums/win_idx valid
- out_ready  in  1  downstream accepts

## Operation
- FSM states and transitions:
  - IDLE: start=1 → READ; row_idx=0, win_idx=0.
  - READ: row_rd_en=1 for exactly one cycle → WAIT; wait_cnt=0.
  - WAIT: wait_cnt increments each cycle. When wait_cnt==CL_LATENCY, capture correlation_line outputs on that edge.
    - row_idx==0: accumulators load the captured values (implicit clear).
    - Otherwise: accumulators add the captured values.
    - row_idx==T_ROWS-1 → OUT; otherwise row_idx+1 → READ.
  - OUT: out_valid=1. sum_*, win_idx are held stable until out_valid&out_ready. On handshake:
    - win_idx==NUM_WIN-1 → IDLE and done=1 the following cycle.
    - Otherwise win_idx+1, row_idx=0 → READ.
- Addresses: img_row_addr/tmpl_row_addr are driven from row_idx/win_idx in every state. They are only meaningful with row_rd_en.
- Arithmetic: unsigned zero-extended add into ACC_W bits. Overflow is impossible by ACC_W sizing; no saturation.
- start is ignored while busy. out_ready is ignored outside OUT.
- Reset (any time, including mid-window or during OUT stall):
  - State returns to IDLE; all counters and accumulators go to 0.
  - busy, done, out_valid and row_rd_en all go to 0.
  - No partial window is ever presented afterwards.

## Timing
- Reset values: every output is 0.
- start accepted at edge k: READ occupies cycle k+1.
- Per row: 2+CL_LATENCY cycles (READ, then CL_LATENCY+1 WAIT cycles).
  - Capture happens on the edge ending cycle (READ cycle)+1+CL_LATENCY.
- out_valid first rises T_ROWS*(2+CL_LATENCY) cycles after the start-accept edge.
- After an OUT handshake, the next window's READ is in the very next cycle; there are no bubbles beyond the FSM.
- done: high in the first IDLE cycle after the final handshake, low otherwise. A start in that same cycle is accepted.
- Stalled OUT (out_ready=0) holds indefinitely with outputs unchanged.

## Test plan
- Bench model, used throughout:
  - Image row r holds all pixels = r+1; template rows hold all pixels = 2.
  - correlation_line model: I=p, I²=p², T×I=2p.
- Basic pass (CL_LATENCY=1, T_ROWS=3, IMG_ROWS=5), out_ready=1 → three windows, identical for every column and template:
  - win_idx 0: sum_I=6, sum_I2=14, sum_TI=12.
  - win_idx 1: sum_I=9, sum_I2=29, sum_TI=18.
  - win_idx 2: sum_I=12, sum_I2=50, sum_TI=24.
  - Timing: out_valid first at cycle 10 after the start edge at cycle 0; done 1 cycle after the third handshake.
- Back-pressure: out_ready=0 for 20 cycles during window 1 → out_valid stays 1, sums stay 9/29/18, row_rd_en stays 0. Release → window 2 READ in the next cycle.
- CL_LATENCY=0, T_ROWS=1, IMG_ROWS=1 → one window: sum_I=1 at 2 cycles after start, then done pulse.
- RST asserted in WAIT of window 1 row 2 → all outputs 0 asynchronously. A new start then yields window 0 sums 6/14/12 (no stale accumulation).
- start held high through a whole pass → no restart while busy. A second pass begins in the done cycle; its windows match the basic pass.
- Max value: all pixels 255, T_ROWS=3 → sum_I2=195075 per column, exact with no wrap in ACC_W.
